// File: rtl/interlaced_sync_generator_if.sv
// Timing bus for the interlaced sync generator: pixel enable in, composite sync,
// field identity and raster position out.
interface interlaced_sync_generator_if;
  logic       pixelClockX1_en;
  logic       hSync;
  logic       vSync;
  logic       isFieldOdd;
  logic       fieldStart;
  logic [9:0] pixelCount;
  logic [9:0] lineCount;

  modport master (
    input  pixelClockX1_en,
    output hSync,
    output vSync,
    output isFieldOdd,
    output fieldStart,
    output pixelCount,
    output lineCount
  );

  modport slave (
    output pixelClockX1_en,
    input  hSync,
    input  vSync,
    input  isFieldOdd,
    input  fieldStart,
    input  pixelCount,
    input  lineCount
  );
endinterface

// File: rtl/interlaced_sync_generator.sv
// Interlaced hSync/vSync/field generator; field identity is encoded by the phase
// of the vSync fall relative to hSync (line start for odd, mid-line for even).
module interlaced_sync_generator #(
  parameter int H_TOTAL         = 864,
  parameter int H_SYNC_WIDTH    = 64,
  parameter int LINES_PER_FRAME = 625,
  parameter int V_SYNC_LINES    = 3
) (
  input  logic                          pixelClockX6,
  input  logic                          reset,
  interlaced_sync_generator_if.master   sync
);

  localparam int F2 = (LINES_PER_FRAME - 1) / 2;
  localparam int HM = H_TOTAL / 2;

  localparam logic [9:0] PIX_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] LINE_LAST   = 10'(LINES_PER_FRAME - 1);
  localparam logic [9:0] HSYNC_END   = 10'(H_SYNC_WIDTH);
  localparam logic [9:0] F1_VS_END   = 10'(V_SYNC_LINES);
  localparam logic [9:0] F2_LINE     = 10'(F2);
  localparam logic [9:0] F2_VS_END   = 10'(F2 + V_SYNC_LINES);
  localparam logic [9:0] HALF_LINE   = 10'(HM);

  if (H_TOTAL < 4 || H_TOTAL > 1024 || (H_TOTAL % 2) != 0) begin : g_bad_h_total
    $error("H_TOTAL must be even and within 4..1024");
  end
  if (H_SYNC_WIDTH < 1 || H_SYNC_WIDTH > HM - 1) begin : g_bad_h_sync
    $error("H_SYNC_WIDTH must be within 1..H_TOTAL/2-1");
  end
  if (LINES_PER_FRAME < 5 || LINES_PER_FRAME > 1024 || (LINES_PER_FRAME % 2) != 1) begin : g_bad_lines
    $error("LINES_PER_FRAME must be odd and within 5..1024");
  end
  if (V_SYNC_LINES < 1 || V_SYNC_LINES > F2 - 1) begin : g_bad_v_sync
    $error("V_SYNC_LINES must be within 1..(LINES_PER_FRAME-1)/2-1");
  end

  logic [9:0] pixel_count_q, pixel_count_d;
  logic [9:0] line_count_q,  line_count_d;
  logic       hsync_q,       hsync_d;
  logic       vsync_q,       vsync_d;
  logic       field_odd_q,   field_odd_d;
  logic       field_start_q, field_start_d;

  logic [9:0] pix_nxt;
  logic [9:0] line_nxt;
  logic       line_wrap;
  logic       f1_vs_low;
  logic       f2_vs_low;
  logic       hsync_nxt;
  logic       vsync_nxt;
  logic       vsync_fall;

  // Next raster position and its decode; sync outputs describe the new position.
  always_comb begin
    line_wrap  = (pixel_count_q == PIX_LAST);
    pix_nxt    = line_wrap ? 10'd0 : pixel_count_q + 10'd1;
    line_nxt   = line_count_q;
    if (line_wrap) begin
      line_nxt = (line_count_q == LINE_LAST) ? 10'd0 : line_count_q + 10'd1;
    end

    hsync_nxt  = (pix_nxt >= HSYNC_END);
    f1_vs_low  = (line_nxt < F1_VS_END);
    f2_vs_low  = ((line_nxt == F2_LINE) && (pix_nxt >= HALF_LINE)) ||
                 ((line_nxt >  F2_LINE) && (line_nxt < F2_VS_END)) ||
                 ((line_nxt == F2_VS_END) && (pix_nxt < HALF_LINE));
    vsync_nxt  = !(f1_vs_low || f2_vs_low);
    vsync_fall = vsync_q && !vsync_nxt;
  end

  always_comb begin
    pixel_count_d = pixel_count_q;
    line_count_d  = line_count_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    field_odd_d   = field_odd_q;
    field_start_d = 1'b0;
    if (sync.pixelClockX1_en) begin
      pixel_count_d = pix_nxt;
      line_count_d  = line_nxt;
      hsync_d       = hsync_nxt;
      vsync_d       = vsync_nxt;
      field_start_d = vsync_fall;
      // Field flag flips only on the vSync fall that opens each field.
      if (vsync_fall && (line_nxt == 10'd0)) begin
        field_odd_d = 1'b1;
      end else if (vsync_fall && (line_nxt == F2_LINE)) begin
        field_odd_d = 1'b0;
      end
    end
  end

  // Reset parks the raster on the last tick of a frame so the first enabled
  // edge opens field 1 at (0,0).
  always_ff @(posedge pixelClockX6) begin
    if (reset) begin
      pixel_count_q <= PIX_LAST;
      line_count_q  <= LINE_LAST;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      field_odd_q   <= 1'b0;
      field_start_q <= 1'b0;
    end else begin
      pixel_count_q <= pixel_count_d;
      line_count_q  <= line_count_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      field_odd_q   <= field_odd_d;
      field_start_q <= field_start_d;
    end
  end

  assign sync.pixelCount = pixel_count_q;
  assign sync.lineCount  = line_count_q;
  assign sync.hSync      = hsync_q;
  assign sync.vSync      = vsync_q;
  assign sync.isFieldOdd = field_odd_q;
  assign sync.fieldStart = field_start_q;

endmodule

// File: doc/interlaced_sync_generator.md
Name: interlaced_sync_generator

Overview:
- Generates the interlaced composite timing (hSync, vSync, field flag) for the VP415 video path, so downstream FPGA logic can run its own line/field counters without the Pi DPI.
- Encodes field identity the same way the DPI does:
  - odd field: vSync falls coincident with a line start, while hSync is low;
  - even field: vSync falls at mid-line, while hSync is high.
- Exposes pixel/line counters and a field-start strobe for the overlay and genlock logic.

Parameters:
- H_TOTAL, 864, enabled pixel ticks per line; even; 4..1024.
- H_SYNC_WIDTH, 64, hSync low duration in pixel ticks; must be 1..H_TOTAL/2-1.
- LINES_PER_FRAME, 625, lines per frame; odd; 5..1024.
- V_SYNC_LINES, 3, vSync low duration in lines, per field; must be 1..(LINES_PER_FRAME-1)/2-1.

Ports:
- pixelClockX6  input  1  system clock, 6x pixel rate.
- reset  input  1  synchronous, active-high; overrides pixelClockX1_en.
- pixelClockX1_en  input  1  pixel-rate enable; all state advances only on edges where it is high.
- hSync  output  1  active-low line sync.
- vSync  output  1  active-low field sync.
- isFieldOdd  output  1  1 = odd (first) field; updates with the vSync falling edge.
- fieldStart  output  1  one-pixelClockX6-cycle strobe on each vSync falling edge.
- pixelCount  output  10  current pixel in line, 0..H_TOTAL-1.
- lineCount  output  10  current line in frame, 0..LINES_PER_FRAME-1.

Behaviour:
- All outputs are registered; no combinational paths from inputs to outputs.
- Reset values:
  - pixelCount=H_TOTAL-1, lineCount=LINES_PER_FRAME-1 (the last tick of a frame);
  - hSync=1, vSync=1, isFieldOdd=0, fieldStart=0.
- Counters, on each enabled edge:
  - pixelCount increments and wraps H_TOTAL-1 -> 0;
  - on that wrap, lineCount increments and wraps LINES_PER_FRAME-1 -> 0.
- Output decode: outputs are updated on the same enabled edge as the counters and always describe the new counter values (zero latency relative to pixelCount/lineCount).
- hSync = 0 iff pixelCount < H_SYNC_WIDTH, on every line including during vSync.
- Field 1 (odd) vSync:
  - low from (line 0, pixel 0) inclusive to (line V_SYNC_LINES, pixel 0) exclusive.
- Field 2 (even) vSync, with F2 = (LINES_PER_FRAME-1)/2 and HM = H_TOTAL/2:
  - low from (line F2, pixel HM) inclusive to (line F2+V_SYNC_LINES, pixel HM) exclusive.
- vSync is high at all other positions.
- Field flag:
  - on the enabled edge where vSync goes 1->0 at line 0, isFieldOdd<=1;
  - at line F2, isFieldOdd<=0;
  - it is held otherwise.
- fieldStart:
  - =1 for exactly one pixelClockX6 cycle, the cycle following an enabled edge that produced a vSync 1->0 transition;
  - =0 on every other cycle, including enable-low cycles.
- Consequence to be guaranteed: at every vSync falling edge, hSync = 0 for field 1 and hSync = 1 for field 2.
- Enable low: counters, hSync, vSync and isFieldOdd hold; fieldStart=0.
- Reset mid-frame:
  - next edge returns all outputs to reset values regardless of enable;
  - the first enabled edge after reset release starts field 1: (0,0), hSync=0, vSync=0, isFieldOdd=1, fieldStart pulse.
- Arithmetic: unsigned 10-bit compares. F2 and HM are constant parameter expressions, not runtime division.
- Parameter violations are a synthesis-time error via generate-time check; no runtime handling.

Test Plan:
Bench parameters: H_TOTAL=16, H_SYNC_WIDTH=2, LINES_PER_FRAME=11, V_SYNC_LINES=2 (F2=5, HM=8, frame = 176 enabled ticks). pixelClockX1_en is high 1 cycle in 6 unless stated.
- Reset held 3 cycles, then released -> outputs hold 15/10/1/1/0/0 until the first enabled edge. That edge gives pixelCount=0, lineCount=0, hSync=0, vSync=0, isFieldOdd=1, and fieldStart high for exactly 1 clock.
- Free-run one frame -> hSync low exactly at pixelCount 0..1 on all 11 lines (22 low ticks per frame). No glitch at line wrap 10->0.
- Field 1 -> vSync low for 32 consecutive enabled ticks (lines 0-1) and rises at (2,0). isFieldOdd stays 1 across the rise.
- Field 2 -> on the 89th enabled tick after frame start, vSync falls at (5,8) with hSync=1, isFieldOdd->0 and a fieldStart pulse. vSync stays low for 32 ticks and rises at (7,8). The second frame then repeats field 1 with isFieldOdd->1.
- Enable gating -> pixelClockX1_en held low for 50 cycles at (5,7): all outputs frozen and fieldStart=0. The next enabled edge produces the field-2 fall at (5,8).
- Reset asserted coincident with an enabled edge at (8,3) -> next state equals reset values. Enable alone does not advance while reset is high.
